// File: rtl/z80_bus_cycle.sv
// Z80 non-M1 bus-cycle sequencer: memory/I/O read and write cycles with
// automatic and nWAIT-stretched wait states. clk runs at 2x the T-state rate.
module z80_bus_cycle #(
    parameter int ADDR_W    = 16,
    parameter int MEM_WAITS = 0,
    parameter int IO_WAITS  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              activate,
    input  logic              io,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    input  logic [7:0]        D_in,
    input  logic              nWAIT,
    output logic [ADDR_W-1:0] A,
    output logic [7:0]        D_out,
    output logic              data_out_en,
    output logic              nMREQ,
    output logic              nIORQ,
    output logic              nRD,
    output logic              nWR,
    output logic [7:0]        rdata,
    output logic [2:0]        tcycle,
    output logic              slot,
    output logic              busy,
    output logic              done
);

    typedef enum logic [3:0] {
        S_IDLE, S_T1H, S_T1L, S_T2H, S_T2L, S_TWH, S_TWL, S_T3H, S_T3L
    } state_t;

    state_t     state, ns;
    logic       io_q, rd_q, wr_q;
    logic [7:0] wcnt;      // TW states completed, saturates at N
    logic       more;      // last nWAIT sample was low: one more TW
    logic [7:0] nwaits;
    logic       accept, wlast, auto_more, sample;
    logic       in_act, in_io, in_oe, wr_win;
    logic       mreq_d, iorq_d, rd_d, wr_d, oe_d;

    assign nwaits    = io_q ? 8'(IO_WAITS) : 8'(MEM_WAITS);
    assign accept    = activate && (rd ^ wr);
    // this TW is the last automatic one, or already an extra one
    assign wlast     = ({1'b0, wcnt} + 9'd1) >= {1'b0, nwaits};
    assign auto_more = ({1'b0, wcnt} + 9'd1) <  {1'b0, nwaits};
    assign sample    = (state == S_T2H && nwaits == 8'd0) || (state == S_TWH && wlast);

    // next-state sequencing
    always_comb begin
        ns = state;
        case (state)
            S_IDLE: if (accept) ns = S_T1H;
            S_T1H:  ns = S_T1L;
            S_T1L:  ns = S_T2H;
            S_T2H:  ns = S_T2L;
            S_T2L:  ns = (nwaits != 8'd0 || more) ? S_TWH : S_T3H;
            S_TWH:  ns = S_TWL;
            S_TWL:  ns = (auto_more || more) ? S_TWH : S_T3H;
            S_T3H:  ns = S_T3L;
            S_T3L:  ns = accept ? S_T1H : S_IDLE;
            default: ns = S_IDLE;
        endcase
    end

    // strobe values for the state being entered; registered below so each
    // output changes on the edge that starts its state
    always_comb begin
        in_act = (ns == S_T1L) || (ns == S_T2H) || (ns == S_T2L) ||
                 (ns == S_TWH) || (ns == S_TWL) || (ns == S_T3H);
        in_io  = in_act && (ns != S_T1L);
        in_oe  = in_act || (ns == S_T3L);
        // with no automatic waits the memory write strobe starts in T2.L
        wr_win = (ns == S_TWH) || (ns == S_TWL) || (ns == S_T3H) ||
                 (nwaits == 8'd0 && ns == S_T2L);
        mreq_d = !(!io_q && in_act);
        iorq_d = !(io_q && in_io);
        rd_d   = !(rd_q && (io_q ? in_io : in_act));
        wr_d   = !(wr_q && (io_q ? in_io : wr_win));
        oe_d   = wr_q && in_oe;
    end

    // state, request latches, wait tracking and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            io_q        <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            wcnt        <= 8'd0;
            more        <= 1'b0;
            A           <= '0;
            D_out       <= 8'd0;
            rdata       <= 8'd0;
            nMREQ       <= 1'b1;
            nIORQ       <= 1'b1;
            nRD         <= 1'b1;
            nWR         <= 1'b1;
            data_out_en <= 1'b0;
            done        <= 1'b0;
        end else begin
            state <= ns;
            if (ns == S_T1H) begin
                io_q  <= io;
                rd_q  <= rd;
                wr_q  <= wr;
                A     <= addr;
                D_out <= wdata;
                wcnt  <= 8'd0;
            end else if (state == S_TWL && wcnt < nwaits) begin
                wcnt <= wcnt + 8'd1;
            end
            if (sample) more <= ~nWAIT;
            // memory reads capture leaving the last T2/TW, I/O reads leaving T3.H
            if ((!io_q && rd_q && (state == S_T2L || state == S_TWL) && ns == S_T3H) ||
                (io_q && rd_q && state == S_T3H))
                rdata <= D_in;
            nMREQ       <= mreq_d;
            nIORQ       <= iorq_d;
            nRD         <= rd_d;
            nWR         <= wr_d;
            data_out_en <= oe_d;
            done        <= (ns == S_T3L);
        end
    end

    // T-state / slot decode
    always_comb begin
        tcycle = 3'd0;
        slot   = 1'b0;
        case (state)
            S_T1H: tcycle = 3'd1;
            S_T1L: begin tcycle = 3'd1; slot = 1'b1; end
            S_T2H: tcycle = 3'd2;
            S_T2L: begin tcycle = 3'd2; slot = 1'b1; end
            S_TWH: tcycle = 3'd7;
            S_TWL: begin tcycle = 3'd7; slot = 1'b1; end
            S_T3H: tcycle = 3'd3;
            S_T3L: begin tcycle = 3'd3; slot = 1'b1; end
            default: ;
        endcase
        busy = (tcycle != 3'd0);
    end

endmodule

// File: tb/tb_z80_bus_cycle.sv
// Directed bench for z80_bus_cycle: default-parameter instance plus a
// MEM_WAITS=2 instance, checked one clk at a time against hand-computed states.
module tb_z80_bus_cycle;

    logic        clk = 0, reset = 0, activate = 0, activate2 = 0;
    logic        io = 0, rd = 0, wr = 0, nWAIT = 1;
    logic [15:0] addr = 0;
    logic [7:0]  wdata = 0, D_in = 0;

    logic [15:0] A, A2;
    logic [7:0]  D_out, D_out2, rdata, rdata2;
    logic        oe, oe2, nMREQ, nMREQ2, nIORQ, nIORQ2, nRD, nRD2, nWR, nWR2;
    logic [2:0]  tcycle, tcycle2;
    logic        slot, slot2, busy, busy2, done, done2;

    z80_bus_cycle dut (
        .clk(clk), .reset(reset), .activate(activate), .io(io), .rd(rd), .wr(wr),
        .addr(addr), .wdata(wdata), .D_in(D_in), .nWAIT(nWAIT), .A(A), .D_out(D_out),
        .data_out_en(oe), .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR),
        .rdata(rdata), .tcycle(tcycle), .slot(slot), .busy(busy), .done(done));

    z80_bus_cycle #(.MEM_WAITS(2)) dut2 (
        .clk(clk), .reset(reset), .activate(activate2), .io(io), .rd(rd), .wr(wr),
        .addr(addr), .wdata(wdata), .D_in(D_in), .nWAIT(nWAIT), .A(A2), .D_out(D_out2),
        .data_out_en(oe2), .nMREQ(nMREQ2), .nIORQ(nIORQ2), .nRD(nRD2), .nWR(nWR2),
        .rdata(rdata2), .tcycle(tcycle2), .slot(slot2), .busy(busy2), .done(done2));

    always #5 clk = ~clk;

    logic [10:0] st, st2;
    assign st  = {tcycle, slot, busy, nMREQ, nIORQ, nRD, nWR, oe, done};
    assign st2 = {tcycle2, slot2, busy2, nMREQ2, nIORQ2, nRD2, nWR2, oe2, done2};

    int compared = 0, mismatched = 0;

    // expected status vector: tcycle, slot, mreq, iorq, rd, wr, oe, done
    function automatic logic [10:0] S(input int tc, input int sl, input int m, input int i,
                                      input int r, input int w, input int e, input int d);
        return {3'(tc), 1'(sl), (tc != 0), 1'(m), 1'(i), 1'(r), 1'(w), 1'(e), 1'(d)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [10:0] exp, input bit second = 0);
        @(posedge clk);
        #1;
        chk(tag, 32'(second ? st2 : st), 32'(exp));
    endtask

    initial begin
        // reset state
        #1 reset = 1;
        #2;
        chk("reset st", 32'(st), 32'(S(0,0,1,1,1,1,0,0)));
        chk("reset rdata", 32'(rdata), 32'h0);
        chk("reset A", 32'(A), 32'h0);
        chk("reset D_out", 32'(D_out), 32'h0);
        @(posedge clk); #1;
        reset = 0;

        // memory read, no waits
        addr = 16'h1234; D_in = 8'h5A; io = 0; rd = 1; wr = 0; activate = 1;
        step("mr T1H", S(1,0,1,1,1,1,0,0)); activate = 0;
        step("mr T1L", S(1,1,0,1,0,1,0,0));
        step("mr T2H", S(2,0,0,1,0,1,0,0));
        step("mr T2L", S(2,1,0,1,0,1,0,0));
        step("mr T3H", S(3,0,0,1,0,1,0,0));
        chk("mr rdata", 32'(rdata), 32'h5A);
        step("mr T3L", S(3,1,1,1,1,1,0,1));
        chk("mr A", 32'(A), 32'h1234);
        step("mr idle", S(0,0,1,1,1,1,0,0));

        // memory write, nWAIT low at T2.H and first TW samples
        addr = 16'h4000; wdata = 8'hC3; rd = 0; wr = 1; activate = 1;
        step("mw T1H", S(1,0,1,1,1,1,0,0)); activate = 0;
        step("mw T1L", S(1,1,0,1,1,1,1,0));
        chk("mw D_out", 32'(D_out), 32'hC3);
        step("mw T2H", S(2,0,0,1,1,1,1,0)); nWAIT = 0;
        step("mw T2L", S(2,1,0,1,1,0,1,0));
        step("mw TW1H", S(7,0,0,1,1,0,1,0));
        step("mw TW1L", S(7,1,0,1,1,0,1,0)); nWAIT = 1;
        step("mw TW2H", S(7,0,0,1,1,0,1,0));
        step("mw TW2L", S(7,1,0,1,1,0,1,0));
        step("mw T3H", S(3,0,0,1,1,0,1,0));
        step("mw T3L", S(3,1,1,1,1,1,1,1));
        step("mw idle", S(0,0,1,1,1,1,0,0));
        chk("mw D_out hold", 32'(D_out), 32'hC3);

        // I/O read, nWAIT low only during T2 (not a sample point with IO_WAITS=1)
        addr = 16'h0042; D_in = 8'h77; io = 1; rd = 1; wr = 0; activate = 1;
        step("ior T1H", S(1,0,1,1,1,1,0,0)); activate = 0;
        step("ior T1L", S(1,1,1,1,1,1,0,0)); nWAIT = 0;
        step("ior T2H", S(2,0,1,0,0,1,0,0));
        step("ior T2L", S(2,1,1,0,0,1,0,0)); nWAIT = 1;
        step("ior TWH", S(7,0,1,0,0,1,0,0));
        step("ior TWL", S(7,1,1,0,0,1,0,0)); D_in = 8'hA5;
        step("ior T3H", S(3,0,1,0,0,1,0,0));
        chk("ior rdata early", 32'(rdata), 32'h5A);
        step("ior T3L", S(3,1,1,1,1,1,0,1));
        chk("ior rdata", 32'(rdata), 32'hA5);
        step("ior idle", S(0,0,1,1,1,1,0,0));

        // MEM_WAITS=2 memory read on the second instance
        addr = 16'h0100; D_in = 8'h3C; io = 0; rd = 1; wr = 0; activate2 = 1;
        step("mw2 T1H", S(1,0,1,1,1,1,0,0), 1); activate2 = 0;
        step("mw2 T1L", S(1,1,0,1,0,1,0,0), 1);
        step("mw2 T2H", S(2,0,0,1,0,1,0,0), 1);
        step("mw2 T2L", S(2,1,0,1,0,1,0,0), 1);
        step("mw2 TW1H", S(7,0,0,1,0,1,0,0), 1);
        step("mw2 TW1L", S(7,1,0,1,0,1,0,0), 1);
        step("mw2 TW2H", S(7,0,0,1,0,1,0,0), 1);
        step("mw2 TW2L", S(7,1,0,1,0,1,0,0), 1);
        step("mw2 T3H", S(3,0,0,1,0,1,0,0), 1);
        chk("mw2 rdata", 32'(rdata2), 32'h3C);
        step("mw2 T3L", S(3,1,1,1,1,1,0,1), 1);
        chk("mw2 other idle", 32'(st), 32'(S(0,0,1,1,1,1,0,0)));
        step("mw2 idle", S(0,0,1,1,1,1,0,0), 1);

        // back-to-back: memory write then I/O read accepted at T3.L
        addr = 16'h2000; wdata = 8'h96; io = 0; rd = 0; wr = 1; activate = 1;
        step("bb w T1H", S(1,0,1,1,1,1,0,0)); activate = 0;
        step("bb w T1L", S(1,1,0,1,1,1,1,0));
        step("bb w T2H", S(2,0,0,1,1,1,1,0));
        step("bb w T2L", S(2,1,0,1,1,0,1,0));
        step("bb w T3H", S(3,0,0,1,1,0,1,0));
        step("bb w T3L", S(3,1,1,1,1,1,1,1));
        addr = 16'h00AB; D_in = 8'hE1; io = 1; rd = 1; wr = 0; activate = 1;
        step("bb r T1H", S(1,0,1,1,1,1,0,0)); activate = 0;
        chk("bb A", 32'(A), 32'h00AB);
        step("bb r T1L", S(1,1,1,1,1,1,0,0));
        step("bb r T2H", S(2,0,1,0,0,1,0,0));
        step("bb r T2L", S(2,1,1,0,0,1,0,0));
        step("bb r TWH", S(7,0,1,0,0,1,0,0));
        step("bb r TWL", S(7,1,1,0,0,1,0,0));
        step("bb r T3H", S(3,0,1,0,0,1,0,0));
        step("bb r T3L", S(3,1,1,1,1,1,0,1));
        chk("bb rdata", 32'(rdata), 32'hE1);
        step("bb idle", S(0,0,1,1,1,1,0,0));

        // illegal requests are ignored
        io = 0; rd = 1; wr = 1; activate = 1;
        step("ill rdwr 1", S(0,0,1,1,1,1,0,0));
        step("ill rdwr 2", S(0,0,1,1,1,1,0,0));
        rd = 0; wr = 0;
        step("ill none", S(0,0,1,1,1,1,0,0));
        activate = 0;

        // reset during TW.H of a memory write
        addr = 16'h3333; wdata = 8'h5F; io = 0; rd = 0; wr = 1; activate = 1;
        step("rst T1H", S(1,0,1,1,1,1,0,0)); activate = 0;
        step("rst T1L", S(1,1,0,1,1,1,1,0));
        step("rst T2H", S(2,0,0,1,1,1,1,0)); nWAIT = 0;
        step("rst T2L", S(2,1,0,1,1,0,1,0));
        step("rst TWH", S(7,0,0,1,1,0,1,0)); nWAIT = 1;
        reset = 1;
        #1;
        chk("rst async st", 32'(st), 32'(S(0,0,1,1,1,1,0,0)));
        chk("rst async A", 32'(A), 32'h0);
        chk("rst async D_out", 32'(D_out), 32'h0);
        chk("rst async rdata", 32'(rdata), 32'h0);
        step("rst held", S(0,0,1,1,1,1,0,0));
        reset = 0;
        step("rst release 1", S(0,0,1,1,1,1,0,0));
        step("rst release 2", S(0,0,1,1,1,1,0,0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
